// File: rtl/gray_pkg.sv
// Shared helpers for the Gray-code counter: encode/decode functions and limits.
package gray_pkg;

    localparam int MAX_W     = 32;
    localparam int DEF_WIDTH = 3;
    localparam logic [DEF_WIDTH-1:0] CNT_MAX = {DEF_WIDTH{1'b1}};

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Decode: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] gc);
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = gc[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--)
            b[i] = b[i+1] ^ gc[i];
        return b;
    endfunction

endpackage

// File: rtl/bin2gray_enc.sv
// Combinational WIDTH-bit binary-to-Gray encoder.
module bin2gray_enc
    import gray_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    logic [MAX_W-1:0] bin_ext;
    logic [MAX_W-1:0] gray_ext;

    assign bin_ext  = MAX_W'(bin);
    assign gray_ext = bin2gray(bin_ext);
    assign gray     = gray_ext[WIDTH-1:0];

endmodule

// File: rtl/gray_counter.sv
// Up/down Gray counter: binary count register, Gray output registered straight
// from the encoder on the next-state value, plus tick/wrap pulses.
module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] g,
    output logic             tick,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LIM = {WIDTH{1'b1}};

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] g_nxt;
    logic             wrap_nxt;

    always_comb begin
        cnt_nxt  = cnt;
        wrap_nxt = 1'b0;
        if (load) begin
            cnt_nxt = load_bin;
        end else if (en) begin
            if (up) begin
                if (cnt == LIM) begin
                    // Saturating build simply holds at the limit.
                    if (WRAP) begin
                        cnt_nxt  = '0;
                        wrap_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end else begin
                if (cnt == '0) begin
                    if (WRAP) begin
                        cnt_nxt  = LIM;
                        wrap_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
        end
    end

    bin2gray_enc #(.WIDTH(WIDTH)) u_enc (
        .bin  (cnt_nxt),
        .gray (g_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            g    <= '0;
            tick <= 1'b0;
            wrap <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            g    <= g_nxt;
            tick <= (g_nxt != g);
            wrap <= wrap_nxt;
        end
    end

endmodule

// File: doc/gray_counter.md
# gray_counter

Parameterised up/down Gray-code counter producing the Gray code word that feeds the Gray-to-binary decode stage directly downstream. The count is held internally in binary, and every registered output word differs from its predecessor in exactly one bit. A parallel load, wrap/saturate selection, and single-cycle status strobes let sequencing logic drive the decoder without glitching multi-bit transitions.

## Interface
- WIDTH, 3: counter and code width in bits (≥2).
- WRAP, 1: 1 = modulo-2^WIDTH wrap at the limits; 0 = saturate at the limits.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement (binary sense).
- load  input  1  synchronous parallel load, with priority over en.
- load_bin  input  WIDTH  binary value to load.
- g  output  WIDTH  registered Gray code of the internal binary count.
- tick  output  1  one-cycle pulse: g changed on this edge.
- wrap  output  1  one-cycle pulse: count wrapped (WRAP=1 only).

## Operation
- Internal state is binary register cnt[WIDTH-1:0]. Output g = cnt ^ (cnt >> 1), registered, never decoded combinationally from cnt.
- Per-edge priority: load > en > hold.
- On load: cnt ← load_bin and g ← load_bin ^ (load_bin >> 1). tick = 1 if the new g differs from the old g, else 0. wrap = 0. A load may change several bits of g at once; this is the only multi-bit change allowed.
- On en with up=1: cnt ← cnt+1 (mod 2^WIDTH).
- On en with up=0: cnt ← cnt−1 (mod 2^WIDTH).
- Wrap cases:
  - Up from all-ones to 0: wrap = 1 if WRAP=1.
  - Down from 0 to all-ones: wrap = 1 if WRAP=1.
  - If WRAP=0, cnt holds at the limit, tick = 0, and wrap = 0.
- While holding (en=0, load=0): g, cnt unchanged; tick = 0; wrap = 0.
- Direction may change on any cycle, with no dead cycle required.

## Timing
- Reset (rst_n low, asynchronous): cnt = 0, g = 0, tick = 0, wrap = 0. Outputs take these values immediately on assertion and remain there while rst_n is low.
- Reset deassertion is sampled synchronously. The first count or load takes effect on the first rising edge at which rst_n is high.
- Latency is 1 cycle: inputs sampled at edge N appear on g, tick, and wrap after edge N.
- Between consecutive en-driven edges, g changes in exactly one bit position (Hamming distance 1), including across the wrap.
- tick and wrap are registered pulses, high for exactly one cycle per qualifying edge. Back-to-back qualifying edges keep them high on consecutive cycles.
- Reset mid-count discards the in-progress value; no pulse is emitted for the reset.

## Structure
- Package gray_pkg:
  - Function bin2gray(WIDTH-generic).
  - Function gray2bin, for bench reference use.
  - Localparam for the all-ones limit, CNT_MAX = {WIDTH{1'b1}}.
- One natural sub-module: bin2gray_enc, a combinational WIDTH-bit encoder. It is instantiated once on the next-state binary value so that g is registered directly from the encoder output.
- The counter, limit detection, and pulse registers live in gray_counter itself. There is no FSM beyond the count register.

## Test plan
- Count up, WIDTH=3, WRAP=1: release reset, hold en=1 and up=1 for 9 cycles.
  - Required: g = 000, 001, 011, 010, 110, 111, 101, 100, 000.
  - wrap = 1 only on the 100→000 step; tick = 1 on every step.
- Count down, WRAP=1: from reset, en=1, up=0.
  - Required: g = 100 (wrap=1), then 101, 111, 110.
  - Bench checks that the Hamming distance between consecutive g values is 1 on every step.
- Load priority: cnt = 2 (g = 011), then load=1, load_bin=5, en=1, up=1 on the same edge.
  - Required: g = 111, tick = 1, wrap = 0, and no increment that cycle.
  - Next en edge: g = 101.
- Saturation, WRAP=0: load 7 (g = 100), then en=1, up=1 for 3 cycles.
  - Required: g stays 100, tick = 0, wrap = 0.
  - Then up=0: g = 101.
- Asynchronous reset mid-count: counting up at g = 110, assert rst_n low between clock edges.
  - Required: g = 000 and tick = wrap = 0 before the next edge.
  - After release with en=1: the first edge yields g = 001.
- Load of the same value: cnt = 3, load_bin = 3.
  - Required: g = 010 unchanged and tick = 0.
